// File: rtl/runway_pkg.sv
// Shared definitions for the runway wind lamp bus: decoder states, lamp codes,
// wind codes and the transition decode table.
package runway_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    localparam int unsigned LAMP_W = 3;
    localparam int unsigned WIND_W = 2;

    localparam logic [LAMP_W-1:0] LAMP_A    = 3'b101;
    localparam logic [LAMP_W-1:0] LAMP_B    = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_C    = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_D    = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_NONE = 3'b000;

    localparam logic [WIND_W-1:0] WIND_CALM = 2'b00;
    localparam logic [WIND_W-1:0] WIND_RTL  = 2'b01;
    localparam logic [WIND_W-1:0] WIND_LTR  = 2'b10;

    // Unknown or X codes fall to the default arm and are treated as illegal.
    function automatic logic is_legal(input logic [LAMP_W-1:0] code);
        case (code)
            LAMP_A, LAMP_B, LAMP_C, LAMP_D: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [WIND_W-1:0] decode(input logic [LAMP_W-1:0] prev,
                                                 input logic [LAMP_W-1:0] cur);
        case ({prev, cur})
            {LAMP_A, LAMP_B}: return WIND_CALM;
            {LAMP_A, LAMP_C}: return WIND_RTL;
            {LAMP_A, LAMP_D}: return WIND_LTR;
            {LAMP_B, LAMP_A}: return WIND_CALM;
            {LAMP_B, LAMP_D}: return WIND_RTL;
            {LAMP_B, LAMP_C}: return WIND_LTR;
            {LAMP_C, LAMP_A}: return WIND_CALM;
            {LAMP_C, LAMP_B}: return WIND_RTL;
            {LAMP_C, LAMP_D}: return WIND_LTR;
            {LAMP_D, LAMP_A}: return WIND_CALM;
            {LAMP_D, LAMP_C}: return WIND_RTL;
            {LAMP_D, LAMP_B}: return WIND_LTR;
            default:          return WIND_CALM;
        endcase
    endfunction

endpackage

// File: rtl/runway_wind_decoder_if.sv
// Lamp bus and decoded-wind bundle between light controller side and decoder.
// Optional RUNWAY_STALL_DETECT_EN adds the stall pulse.
interface runway_wind_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic [2:0]       lights;
    logic [1:0]       wind;
    logic             wind_valid;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
`ifdef RUNWAY_STALL_DETECT_EN
    logic             stall;

    modport master (output lights, input wind, wind_valid, locked, err, err_count, stall);
    modport slave  (input lights, output wind, wind_valid, locked, err, err_count, stall);
`else
    modport master (output lights, input wind, wind_valid, locked, err, err_count);
    modport slave  (input lights, output wind, wind_valid, locked, err, err_count);
`endif
endinterface

// File: rtl/meta_sync.sv
// Two-flop synchroniser for an asynchronous multi-bit level bus.
module meta_sync #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/runway_wind_decoder.sv
// Recovers wind code from runway lamp pattern transitions, locks on a legal
// stream, flags illegal codes. Optional RUNWAY_STALL_DETECT_EN drops lock on a
// pattern that stops changing.
module runway_wind_decoder
    import runway_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned CNT_W     = 8
`ifdef RUNWAY_STALL_DETECT_EN
   ,parameter int unsigned STALL_MAX = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    runway_wind_decoder_if.slave  bus
);
    localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

    logic [LAMP_W-1:0] cur;
    logic              cur_legal;
    logic              is_trans;
    logic [WIND_W-1:0] dec;

    state_e            state_q,      state_d;
    logic [LAMP_W-1:0] prev_q,       prev_d;
    logic [LCW-1:0]    lock_cnt_q,   lock_cnt_d;
    logic [WIND_W-1:0] wind_q,       wind_d;
    logic              wind_valid_q, wind_valid_d;
    logic              locked_q,     locked_d;
    logic              err_q,        err_d;
    logic [CNT_W-1:0]  err_count_q,  err_count_d;

`ifdef RUNWAY_STALL_DETECT_EN
    localparam int unsigned SCW = $clog2(STALL_MAX + 1);
    logic              is_rep;
    logic [SCW-1:0]    stall_cnt_q,  stall_cnt_d;
    logic              stall_q,      stall_d;
`endif

    meta_sync #(.W(LAMP_W)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (bus.lights),
        .q_o   (cur)
    );

    // A transition needs a legal previous code that differs from the current one.
    assign cur_legal = is_legal(cur);
    assign is_trans  = cur_legal && (prev_q != LAMP_NONE) && (cur != prev_q);
    assign dec       = decode(prev_q, cur);
`ifdef RUNWAY_STALL_DETECT_EN
    assign is_rep    = cur_legal && (cur == prev_q);
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = cur_legal ? cur : LAMP_NONE;
        lock_cnt_d   = lock_cnt_q;
        wind_d       = wind_q;
        wind_valid_d = wind_valid_q;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
`ifdef RUNWAY_STALL_DETECT_EN
        stall_cnt_d  = '0;
        stall_d      = 1'b0;
`endif

        case (state_q)
            ST_SEARCH: begin
                if (!cur_legal) begin
                    lock_cnt_d = '0;
                end else if (is_trans) begin
                    if (lock_cnt_q == LCW'(LOCK_CNT - 1)) begin
                        state_d      = ST_LOCKED;
                        locked_d     = 1'b1;
                        wind_valid_d = 1'b1;
                        wind_d       = dec;
                        lock_cnt_d   = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end
                end
            end

            ST_LOCKED: begin
                if (!cur_legal) begin
                    state_d      = ST_FAULT;
                    err_d        = 1'b1;
                    locked_d     = 1'b0;
                    wind_valid_d = 1'b0;
                    if (err_count_q != {CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                end else if (is_trans) begin
                    wind_d = dec;
                end
`ifdef RUNWAY_STALL_DETECT_EN
                else if (is_rep) begin
                    if (stall_cnt_q == SCW'(STALL_MAX - 1)) begin
                        state_d      = ST_SEARCH;
                        locked_d     = 1'b0;
                        wind_valid_d = 1'b0;
                        lock_cnt_d   = '0;
                        stall_d      = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SCW'(1);
                    end
                end
`endif
            end

            ST_FAULT: begin
                state_d    = ST_SEARCH;
                lock_cnt_d = '0;
            end

            default: begin
                state_d    = ST_SEARCH;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SEARCH;
            prev_q       <= LAMP_NONE;
            lock_cnt_q   <= '0;
            wind_q       <= WIND_CALM;
            wind_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            lock_cnt_q   <= lock_cnt_d;
            wind_q       <= wind_d;
            wind_valid_q <= wind_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
        end
    end

`ifdef RUNWAY_STALL_DETECT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.stall = stall_q;
`endif

    assign bus.wind       = wind_q;
    assign bus.wind_valid = wind_valid_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_runway_wind_decoder.sv
// Scoreboard bench for runway_wind_decoder: directed lamp sequences plus random
// traffic checked cycle-by-cycle against a behavioural model.
module tb_runway_wind_decoder;
    import runway_pkg::*;

    localparam int unsigned CW    = 2;
    localparam int          LOCKN = 3;
    localparam int          STALLN = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    runway_wind_decoder_if #(.CNT_W(CW)) bus ();

    runway_wind_decoder #(
        .LOCK_CNT (LOCKN),
        .CNT_W    (CW)
`ifdef RUNWAY_STALL_DETECT_EN
       ,.STALL_MAX(STALLN)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int            due;
        logic [1:0]    wind;
        logic          valid;
        logic          locked;
        logic          err;
        logic [CW-1:0] ecnt;
        logic          stall;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;

    // Wind per (prev,cur) indexed A=0,B=1,C=2,D=3; -1 marks a repeat.
    int lut [4][4] = '{'{-1, 0, 1, 2},
                       '{ 0,-1, 2, 1},
                       '{ 0, 1,-1, 2},
                       '{ 0, 2, 1,-1}};

    logic [2:0] m_prev;
    int         m_run, m_ecnt, m_scnt;
    logic       m_locked, m_valid, m_err, m_stall;
    logic [1:0] m_wind;

    function automatic int code_idx(input logic [2:0] c);
        case (c)
            3'b101:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            3'b100:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_prev = 3'b000; m_run = 0; m_ecnt = 0; m_scnt = 0;
        m_locked = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_stall = 1'b0;
        m_wind = 2'b00;
    endtask

    task automatic model_step(input logic [2:0] c);
        int ci, pi;
        ci = code_idx(c);
        pi = code_idx(m_prev);
        m_err = 1'b0;
        m_stall = 1'b0;
        if (ci < 0) begin
            if (m_locked) begin
                m_err = 1'b1;
                if (m_ecnt < (1 << CW) - 1) m_ecnt++;
                m_locked = 1'b0;
                m_valid = 1'b0;
            end
            m_run = 0;
            m_scnt = 0;
            m_prev = 3'b000;
        end else if (pi < 0) begin
            m_prev = c;
            m_scnt = 0;
        end else if (pi == ci) begin
`ifdef RUNWAY_STALL_DETECT_EN
            if (m_locked) begin
                m_scnt++;
                if (m_scnt == STALLN) begin
                    m_locked = 1'b0; m_valid = 1'b0; m_run = 0;
                    m_stall = 1'b1; m_scnt = 0;
                end
            end
`endif
        end else begin
            m_scnt = 0;
            if (m_locked) begin
                m_wind = 2'(lut[pi][ci]);
            end else begin
                m_run++;
                if (m_run == LOCKN) begin
                    m_locked = 1'b1;
                    m_valid = 1'b1;
                    m_wind = 2'(lut[pi][ci]);
                    m_run = 0;
                end
            end
            m_prev = c;
        end
    endtask

    function automatic logic [6+CW-1:0] pack_dut();
        logic s;
`ifdef RUNWAY_STALL_DETECT_EN
        s = bus.stall;
`else
        s = 1'b0;
`endif
        return {bus.wind, bus.wind_valid, bus.locked, bus.err, bus.err_count, s};
    endfunction

    // Code applied before edge N shows on the outputs after edge N+2.
    task automatic drive(input logic [2:0] c);
        exp_t e;
        @(negedge clk);
        bus.lights = c;
        model_step(c);
        e.due = edge_cnt + 3;
        e.wind = m_wind; e.valid = m_valid; e.locked = m_locked;
        e.err = m_err; e.ecnt = CW'(m_ecnt); e.stall = m_stall;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    endtask

    task automatic check_now(input string name);
        logic [6+CW-1:0] exp_v, got_v;
        exp_v = {m_wind, m_valid, m_locked, m_err, CW'(m_ecnt), m_stall};
        got_v = pack_dut();
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got wind/valid/locked/err/ecnt/stall=%b required %b", name, got_v, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [6+CW-1:0] exp_v, got_v;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (q.size() > 0 && q[0].due <= edge_cnt) begin
                e = q.pop_front();
                exp_v = {e.wind, e.valid, e.locked, e.err, e.ecnt, e.stall};
                got_v = pack_dut();
                n_cmp++;
                if (got_v !== exp_v || e.due != edge_cnt) begin
                    n_bad++;
                    $display("FAIL edge %0d (due %0d): got wind/valid/locked/err/ecnt/stall=%b required %b",
                             edge_cnt, e.due, got_v, exp_v);
                end
            end
        end
    end

    task automatic lock_seq();
        drive(LAMP_A); drive(LAMP_B); drive(LAMP_A); drive(LAMP_B);
    endtask

    initial begin : stim
        logic [2:0] bad_codes [4];
        logic [2:0] good_codes [4];
        logic [2:0] last;
        int r;
        bad_codes  = '{3'b000, 3'b011, 3'b110, 3'b111};
        good_codes = '{LAMP_A, LAMP_B, LAMP_C, LAMP_D};
        bus.lights = 3'b000;
        model_reset();
        repeat (3) @(negedge clk);
        check_now("reset_state");
        reset_n = 1'b1;

        // Lock, then decode sequences.
        lock_seq();
        drive(LAMP_A); drive(LAMP_C); drive(LAMP_B); drive(LAMP_D);
        drive(LAMP_D); drive(LAMP_B); drive(LAMP_C); drive(LAMP_A);
        // Single illegal code while locked, then relock.
        drive(3'b111);
        lock_seq();
        // Counter clear in SEARCH: 2 transitions, illegal, then 3 transitions.
        drive(3'b000);
        drive(LAMP_A); drive(LAMP_B); drive(LAMP_C);
        drive(3'b000);
        drive(LAMP_A); drive(LAMP_B); drive(LAMP_C); drive(LAMP_D);
        // Repeated faults to reach saturation.
        for (int i = 0; i < 5; i++) begin
            lock_seq();
            drive(LAMP_B);
            drive(bad_codes[i % 4]);
            drive(bad_codes[(i + 1) % 4]);
        end
`ifdef RUNWAY_STALL_DETECT_EN
        lock_seq();
        repeat (STALLN + 3) drive(LAMP_B);
`endif
        // Random traffic with repeats and occasional illegal codes.
        last = LAMP_A;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      last = bad_codes[$urandom_range(0, 3)];
            else if (r >= 4) last = good_codes[$urandom_range(0, 3)];
            drive(last);
        end

        // Async reset while locked must clear outputs without a clock edge.
        lock_seq();
        drain();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset");
        bus.lights = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        lock_seq();
        drive(LAMP_C);
        drain();

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/runway_wind_decoder.md
Name: runway_wind_decoder

Overview:
- Ground-side receiver for the runway wind-indicator lamp bus: watches the 3-bit lamp pattern driven by the runway light controller and recovers the wind code (calm / right-to-left / left-to-right) from each pattern transition.
- Synchronises the lamp bus, locks onto a legal pattern stream, reports decoded wind, flags illegal lamp codes and counts faults.
- Sits on the tower-display side of the lamp bus, on a clock asynchronous to the lamp driver.

Parameters:
- LOCK_CNT, 3, consecutive legal transitions required before lock.
- CNT_W, 8, width of the saturating fault counter.
- STALL_MAX, 16, unchanged-pattern cycles tolerated while locked (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- lights  input  3  lamp pattern from the runway light controller, asynchronous.
- wind  output  2  decoded wind: 00 calm, 01 rtl, 10 ltr; 11 is never driven.
- wind_valid  output  1  wind holds a decode made while locked.
- locked  output  1  decoder is in LOCKED.
- err  output  1  one-cycle pulse on an illegal lamp code seen while locked.
- err_count  output  CNT_W  saturating count of err pulses.

Behaviour:
- Interface: one clock domain, clk; reset is asynchronous and active-low on reset_n.
- Reset (async assert, sync release): sync flops=000, prev=000, wind=00, wind_valid=0, locked=0, err=0, err_count=0, state=SEARCH, lock counter=0.
- Legal codes: A=101, B=010, C=001, D=100. Codes 000, 011, 110 and 111 (and X in simulation) are illegal.
- Sync: lights passes through a 2-flop synchroniser to give s2. If lights changes before edge N, wind/wind_valid/err reflect it after edge N+2 (fixed latency of 3 edges).
- Decode table (prev -> cur = wind):
  - A->B 00, A->C 01, A->D 10.
  - B->A 00, B->D 01, B->C 10.
  - C->A 00, C->B 01, C->D 10.
  - D->A 00, D->C 01, D->B 10.
- Every ordered pair of distinct legal codes is a legal transition. The only anomalies are illegal codes and repeats.
- Repeat (cur==prev, legal): no decode. Outputs hold. Lock counter holds.
- prev updates to cur on every legal cur. prev is set to 000 on an illegal cur. A legal cur with prev=000 only loads prev; it counts as no transition.
- State machine (states SEARCH, LOCKED, FAULT):
  - SEARCH: each legal transition increments the lock counter. An illegal code clears the counter with no err. On reaching LOCK_CNT, go to LOCKED on the same edge as the LOCK_CNT-th decode, with locked=1, wind_valid=1, and wind=that decode.
  - LOCKED: each legal transition registers wind and keeps wind_valid=1. An illegal code moves to FAULT and pulses err for exactly 1 cycle, err_count+1, locked=0, wind_valid=0, wind held.
  - FAULT: unconditionally returns to SEARCH on the next edge with the counter cleared. A legal code arriving in FAULT loads prev only.
- err_count saturates at all ones and never wraps. Only reset clears it.
- reset_n asserted mid-operation clears everything immediately, regardless of state.

Optional Feature:
- Macro: RUNWAY_STALL_DETECT_EN.
- Defined: in LOCKED, a counter increments on each repeat cycle and clears on any transition. When it reaches STALL_MAX, the block returns to SEARCH with wind_valid=0, locked=0 and the lock counter cleared, and the extra output stall pulses for 1 cycle. No err is raised and err_count is unchanged.
- Undefined: no stall counter and no stall port. Repeats hold state indefinitely.

Decomposition:
- Package runway_pkg: enum of decoder states; lamp code constants A/B/C/D; wind code constants CALM/RTL/LTR. The light controller and this decoder share the package.
- Sub-module meta_sync: parameterised-width 2-flop synchroniser with async active-low reset, instantiated with width 3.
- Decode table and FSM stay in runway_wind_decoder.

Test Plan:
- Reset, then lights A,B,A,B, 1 cycle each -> locked=1 and wind=00 exactly 3 edges after the 4th code; wind_valid=1; err_count=0.
- Locked, then lights A,C,B,D -> wind=01 on each decode; then D,B,C,A -> wind=10, 10, 00.
- Locked, then lights=111 for 1 cycle -> err high exactly 1 cycle, err_count=1, locked=0, wind_valid=0. Then A,B,A,B -> relock.
- SEARCH after 2 legal transitions, then 000, then 2 more transitions -> still unlocked (counter cleared); the 3rd transition locks.
- CNT_W=2: five separate faults while locked -> err_count reads 1,2,3,3,3.
- Locked with reset_n pulsed low mid-cycle -> all outputs 0 immediately without waiting for clk. With RUNWAY_STALL_DETECT_EN and STALL_MAX=16, holding A for 16 cycles while locked -> stall pulse, locked=0.
